// File: rtl/micro_ctrl_pkg.sv
// micro_ctrl_pkg: shared definitions for the am2910 microprogram sequencer
// controller -- opcode constants, microword field layout, pipeline-register
// image and controller state enumeration.
package micro_ctrl_pkg;

  // am2910 instruction codes the controller cares about
  localparam logic [3:0] OP_JZ   = 4'h0;
  localparam logic [3:0] OP_CJS  = 4'h1;
  localparam logic [3:0] OP_PUSH = 4'h4;
  localparam logic [3:0] OP_JSRP = 4'h5;
  localparam logic [3:0] OP_CONT = 4'hE;

  // Microword field bit positions
  localparam int I_HI     = 31;
  localparam int I_LO     = 28;
  localparam int D_HI     = 27;
  localparam int D_LO     = 16;
  localparam int CSEL_HI  = 15;
  localparam int CSEL_LO  = 13;
  localparam int CPOL_BIT = 12;
  localparam int HBIT_BIT = 11;
  localparam int CTRL_HI  = 10;
  localparam int CTRL_LO  = 0;

  // Controller state; encoding is visible on the STATE port
  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  // Pipeline register image: decoded microword plus the carry-in to the am2910
  typedef struct packed {
    logic [3:0]  i;
    logic [11:0] d;
    logic [2:0]  csel;
    logic        cpol;
    logic        hbit;
    logic [10:0] ctrl;
    logic        ci;
  } pipe_t;

  // HOLD word: CONT with CI=0 keeps the am2910 microaddress frozen
  localparam pipe_t PIPE_HOLD = '{i: OP_CONT, d: 12'h000, csel: 3'd0, cpol: 1'b0,
                                  hbit: 1'b0, ctrl: 11'h000, ci: 1'b0};

  // Reset image: JZ sends the am2910 to address 0
  localparam pipe_t PIPE_RESET = '{i: OP_JZ, d: 12'h000, csel: 3'd0, cpol: 1'b0,
                                   hbit: 1'b0, ctrl: 11'h000, ci: 1'b1};

  // Split a fetched control-store word into pipeline-register fields
  function automatic pipe_t decode_word(input logic [31:0] w);
    pipe_t p;
    p.i    = w[I_HI:I_LO];
    p.d    = w[D_HI:D_LO];
    p.csel = w[CSEL_HI:CSEL_LO];
    p.cpol = w[CPOL_BIT];
    p.hbit = w[HBIT_BIT];
    p.ctrl = w[CTRL_HI:CTRL_LO];
    p.ci   = 1'b1;
    return p;
  endfunction

endpackage

// File: rtl/micro_cc_mux.sv
// micro_cc_mux: condition-code select for the am2910. CSEL=0 means
// "unconditional": CCEN=1 and CC=1. Otherwise the selected live status flag is
// XORed with the polarity bit; CC low means the test passed.
module micro_cc_mux
  import micro_ctrl_pkg::*;
(
  input  logic [2:0] csel_i,
  input  logic       cpol_i,
  input  logic [7:0] cond_i,
  output logic       cc_o,
  output logic       ccen_o
);

  // Select and polarise the live condition flag
  always_comb begin
    ccen_o = (csel_i == 3'd0);
    cc_o   = 1'b1;
    if (csel_i != 3'd0) begin
      cc_o = ~(cond_i[csel_i] ^ cpol_i);
    end
  end

endmodule

// File: rtl/micro_ctrl.sv
// micro_ctrl: run/step/halt controller and pipeline register sitting between
// the control store and an am2910 sequencer. Build option
// MICRO_CTRL_CYCCNT_EN enables the saturating executed-microword counter on
// CYC; without it CYC is tied to 0.
module micro_ctrl
  import micro_ctrl_pkg::*;
(
  input  logic        CP,
  input  logic        RESET_N,
  input  logic [11:0] Y,
  output logic [11:0] CS_A,
  input  logic [31:0] CS_Q,
  input  logic [7:0]  COND,
  input  logic        FULL,
  input  logic        RUN_REQ,
  input  logic        STEP_REQ,
  input  logic        HALT_REQ,
  output logic [3:0]  I,
  output logic [11:0] D,
  output logic        CC,
  output logic        CCEN,
  output logic        CI,
  output logic        RLD,
  output logic        OE,
  output logic [10:0] CTRL,
  output logic [1:0]  STATE,
  output logic [15:0] CYC
);

  state_e state_q, state_d;
  pipe_t  pipe_q, pipe_d;
  logic   fetch;
  logic   push_op;
  logic   fault_hit;

  assign CS_A  = Y;
  assign I     = pipe_q.i;
  assign D     = pipe_q.d;
  assign CI    = pipe_q.ci;
  assign CTRL  = pipe_q.ctrl;
  assign RLD   = 1'b1;
  assign OE    = 1'b0;
  assign STATE = state_q;

  // A stack-pushing instruction issued while the am2910 stack is full is fatal
  assign push_op   = (pipe_q.i == OP_CJS) || (pipe_q.i == OP_PUSH) || (pipe_q.i == OP_JSRP);
  assign fault_hit = ((state_q == ST_RUN) || (state_q == ST_STEP)) && FULL && push_op;

  micro_cc_mux u_cc_mux (
    .csel_i (pipe_q.csel),
    .cpol_i (pipe_q.cpol),
    .cond_i (COND),
    .cc_o   (CC),
    .ccen_o (CCEN)
  );

  // Next state and fetch-or-hold decision
  always_comb begin
    state_d = state_q;
    fetch   = 1'b0;
    case (state_q)
      ST_HALT: begin
        if (!HALT_REQ) begin
          if (RUN_REQ) begin
            state_d = ST_RUN;
            fetch   = 1'b1;
          end else if (STEP_REQ) begin
            state_d = ST_STEP;
            fetch   = 1'b1;
          end
        end
      end
      ST_STEP: begin
        state_d = fault_hit ? ST_FAULT : ST_HALT;
      end
      ST_RUN: begin
        if (fault_hit) begin
          state_d = ST_FAULT;
        end else if (HALT_REQ || pipe_q.hbit) begin
          state_d = ST_HALT;
        end else begin
          fetch = 1'b1;
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase
    pipe_d = fetch ? decode_word(CS_Q) : PIPE_HOLD;
  end

  // State and pipeline register
  always_ff @(posedge CP) begin
    if (!RESET_N) begin
      state_q <= ST_HALT;
      pipe_q  <= PIPE_RESET;
    end else begin
      state_q <= state_d;
      pipe_q  <= pipe_d;
    end
  end

`ifdef MICRO_CTRL_CYCCNT_EN
  logic [15:0] cyc_q, cyc_d;

  // Saturating count of fetched microwords
  always_comb begin
    cyc_d = cyc_q;
    if (fetch && (cyc_q != 16'hFFFF)) begin
      cyc_d = cyc_q + 16'd1;
    end
  end

  // Counter register
  always_ff @(posedge CP) begin
    if (!RESET_N) begin
      cyc_q <= 16'h0000;
    end else begin
      cyc_q <= cyc_d;
    end
  end

  assign CYC = cyc_q;
`else
  assign CYC = 16'h0000;
`endif

endmodule

// File: tb/tb_micro_ctrl.sv
// tb_micro_ctrl: directed bench for micro_ctrl with an in-bench behavioural
// model compared every cycle, plus hand-computed literal expectations.
module tb_micro_ctrl;

`ifdef MICRO_CTRL_CYCCNT_EN
  localparam bit CYC_EN = 1'b1;
`else
  localparam bit CYC_EN = 1'b0;
`endif

  localparam logic [31:0] HOLD_WORD = 32'hE000_0000;

  logic        CP = 1'b0;
  logic        RESET_N;
  logic [11:0] Y;
  logic [11:0] CS_A;
  logic [31:0] CS_Q;
  logic [7:0]  COND;
  logic        FULL;
  logic        RUN_REQ, STEP_REQ, HALT_REQ;
  logic [3:0]  I;
  logic [11:0] D;
  logic        CC, CCEN, CI, RLD, OE;
  logic [10:0] CTRL;
  logic [1:0]  STATE;
  logic [15:0] CYC;

  micro_ctrl dut (
    .CP(CP), .RESET_N(RESET_N), .Y(Y), .CS_A(CS_A), .CS_Q(CS_Q), .COND(COND),
    .FULL(FULL), .RUN_REQ(RUN_REQ), .STEP_REQ(STEP_REQ), .HALT_REQ(HALT_REQ),
    .I(I), .D(D), .CC(CC), .CCEN(CCEN), .CI(CI), .RLD(RLD), .OE(OE),
    .CTRL(CTRL), .STATE(STATE), .CYC(CYC)
  );

  always #5 CP = ~CP;

  int n_run  = 0;
  int n_fail = 0;

  // Model: controller mode (0 halt,1 run,2 step,3 fault), the word last
  // latched for the am2910, whether it was a real fetch, and the fetch count
  int          m_st    = 0;
  logic [31:0] m_w     = 32'h0;
  logic        m_ci    = 1'b1;
  int          m_cyc   = 0;
  bit          m_valid = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_run++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int  nxt;
    bit  fetch;
    int  op;
    bit  pushes;
    if (!RESET_N) begin
      m_st = 0; m_w = 32'h0; m_ci = 1'b1; m_cyc = 0; m_valid = 1'b1;
    end else if (m_valid) begin
      nxt    = m_st;
      fetch  = 1'b0;
      op     = int'(m_w[31:28]);
      pushes = (op == 1) || (op == 4) || (op == 5);
      if (m_st == 3) begin
        nxt = 3;
      end else if ((m_st == 1 || m_st == 2) && FULL && pushes) begin
        nxt = 3;
      end else if (m_st == 0) begin
        if (HALT_REQ) nxt = 0;
        else if (RUN_REQ) begin nxt = 1; fetch = 1'b1; end
        else if (STEP_REQ) begin nxt = 2; fetch = 1'b1; end
      end else if (m_st == 2) begin
        nxt = 0;
      end else begin
        if (HALT_REQ || m_w[11]) nxt = 0;
        else fetch = 1'b1;
      end
      if (fetch) begin
        m_w  = CS_Q;
        m_ci = 1'b1;
        if (CYC_EN && m_cyc < 65535) m_cyc = m_cyc + 1;
      end else begin
        m_w  = HOLD_WORD;
        m_ci = 1'b0;
      end
      m_st = nxt;
    end
  endtask

  task automatic compare_all();
    int csel;
    int exp_cc;
    csel   = int'(m_w[15:13]);
    exp_cc = (csel == 0) ? 1 : int'(~(COND[csel] ^ m_w[12]));
    chk("model STATE", int'(STATE), m_st);
    chk("model I",     int'(I),     int'(m_w[31:28]));
    chk("model D",     int'(D),     int'(m_w[27:16]));
    chk("model CTRL",  int'(CTRL),  int'(m_w[10:0]));
    chk("model CI",    int'(CI),    int'(m_ci));
    chk("model CCEN",  int'(CCEN),  (csel == 0) ? 1 : 0);
    chk("model CC",    int'(CC),    exp_cc & 1);
    chk("model RLD",   int'(RLD),   1);
    chk("model OE",    int'(OE),    0);
    chk("model CYC",   int'(CYC),   m_cyc);
    chk("model CS_A",  int'(CS_A),  int'(Y));
  endtask

  // One clock: model follows the edge, outputs are checked on the falling edge
  task automatic tick();
    @(posedge CP);
    model_step();
    @(negedge CP);
    if (m_valid) compare_all();
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    tick();
    RESET_N = 1'b1;
  endtask

  initial begin
    RESET_N = 1'b0; Y = 12'h000; CS_Q = 32'h0; COND = 8'h00; FULL = 1'b0;
    RUN_REQ = 1'b0; STEP_REQ = 1'b0; HALT_REQ = 1'b0;
    tick(); tick();
    RESET_N = 1'b1;
    chk("reset STATE", int'(STATE), 0);
    chk("reset I",     int'(I),     0);
    chk("reset CCEN",  int'(CCEN),  1);
    chk("reset CC",    int'(CC),    1);
    chk("reset CI",    int'(CI),    1);
    chk("reset CYC",   int'(CYC),   0);
    tick();
    chk("post-reset HOLD I",  int'(I),  4'hE);
    chk("post-reset HOLD CI", int'(CI), 0);

    // Start running
    CS_Q = 32'h4002_0000; RUN_REQ = 1'b1; Y = 12'h123;
    tick();
    RUN_REQ = 1'b0;
    chk("run I",     int'(I),     4);
    chk("run D",     int'(D),     12'h002);
    chk("run CCEN",  int'(CCEN),  1);
    chk("run CC",    int'(CC),    1);
    chk("run STATE", int'(STATE), 1);

    // Condition select on flag 3, positive polarity, live COND
    CS_Q = 32'hE000_6000; Y = 12'h456;
    tick();
    chk("csel3 CCEN", int'(CCEN), 0);
    chk("csel3 CC cond0", int'(CC), 1);
    COND = 8'h08; #1;
    chk("csel3 CC cond1", int'(CC), 0);
    CS_Q = 32'hE000_7000; COND = 8'h00;
    tick();
    chk("csel3 inv CC cond0", int'(CC), 0);
    COND = 8'hF7; #1;
    chk("csel3 inv CC other flags", int'(CC), 0);
    COND = 8'h00;

    // Halt bit in a fetched word
    CS_Q = 32'hE000_0800; Y = 12'hABC;
    tick();
    chk("hbit loaded STATE", int'(STATE), 1);
    chk("hbit loaded CI",    int'(CI),    1);
    CS_Q = 32'h4002_0000;
    tick();
    chk("hbit halt STATE", int'(STATE), 0);
    chk("hbit halt I",     int'(I),     4'hE);
    chk("hbit halt CI",    int'(CI),    0);
    tick();
    chk("hbit held STATE", int'(STATE), 0);

    // Single step from a clean reset
    do_reset();
    tick();
    CS_Q = 32'hE000_0005; STEP_REQ = 1'b1;
    tick();
    STEP_REQ = 1'b0;
    chk("step STATE",  int'(STATE), 2);
    chk("step CTRL",   int'(CTRL),  11'h005);
    chk("step CYC",    int'(CYC),   CYC_EN ? 1 : 0);
    tick();
    chk("step back STATE", int'(STATE), 0);
    chk("step back CTRL",  int'(CTRL),  0);
    chk("step back I",     int'(I),     4'hE);
    chk("step back CI",    int'(CI),    0);

    // HALT_REQ while running
    CS_Q = 32'hE000_0001; RUN_REQ = 1'b1;
    tick();
    RUN_REQ = 1'b0; HALT_REQ = 1'b1;
    tick();
    HALT_REQ = 1'b0;
    chk("halt_req STATE", int'(STATE), 0);
    chk("halt_req I",     int'(I),     4'hE);

    // CJS with a full stack; fault beats a simultaneous HALT_REQ
    CS_Q = 32'h1000_0000; RUN_REQ = 1'b1;
    tick();
    RUN_REQ = 1'b0;
    chk("cjs I", int'(I), 1);
    FULL = 1'b1; HALT_REQ = 1'b1;
    tick();
    FULL = 1'b0; HALT_REQ = 1'b0;
    chk("fault STATE", int'(STATE), 3);
    chk("fault CI",    int'(CI),    0);
    RUN_REQ = 1'b1;
    tick();
    RUN_REQ = 1'b0;
    chk("fault sticky run", int'(STATE), 3);
    STEP_REQ = 1'b1;
    tick();
    STEP_REQ = 1'b0;
    chk("fault sticky step", int'(STATE), 3);
    do_reset();
    chk("fault reset STATE", int'(STATE), 0);
    chk("fault reset I",     int'(I),     0);

    // PUSH stepped with a full stack faults out of STEP
    tick();
    CS_Q = 32'h4000_0000; STEP_REQ = 1'b1;
    tick();
    STEP_REQ = 1'b0; FULL = 1'b1;
    tick();
    FULL = 1'b0;
    chk("step fault STATE", int'(STATE), 3);
    do_reset();

    // Reset in the middle of running
    CS_Q = 32'hE000_0003; RUN_REQ = 1'b1;
    tick();
    RUN_REQ = 1'b0;
    tick(); tick();
    do_reset();
    chk("midrun reset STATE", int'(STATE), 0);
    chk("midrun reset CTRL",  int'(CTRL),  0);

    // Long run for counter saturation
    CS_Q = 32'hE000_0000; RUN_REQ = 1'b1;
    tick();
    RUN_REQ = 1'b0;
    for (int k = 0; k < 70000; k++) begin
      Y = k[11:0];
      tick();
    end
    chk("long run CYC", int'(CYC), CYC_EN ? 16'hFFFF : 0);
    HALT_REQ = 1'b1;
    tick();
    HALT_REQ = 1'b0;
    chk("long run halted", int'(STATE), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/micro_ctrl.md
MICRO_CTRL -- requirements
Module: micro_ctrl

Interface
REQ-001 SHALL have port CP, input, 1, rising-edge clock.
REQ-002 SHALL have port RESET_N, input, 1, reset; synchronous, active-low.
REQ-003 SHALL have port Y, input, 12, next microaddress from the am2910; drives CS_A unchanged.
REQ-004 SHALL have port CS_A, output, 12, control-store address.
REQ-005 SHALL have port CS_Q, input, 32, control-store read data, combinational from CS_A.
REQ-006 SHALL have port COND, input, 8, raw datapath status flags.
REQ-007 SHALL have port FULL, input, 1, am2910 stack-full flag.
REQ-008 SHALL have ports RUN_REQ, STEP_REQ and HALT_REQ, each input, 1, single-cycle operator commands.
REQ-009 SHALL have ports I (4), D (12), CC (1), CCEN (1), CI (1), RLD (1) and OE (1), all outputs, driving the am2910 from the pipeline register.
REQ-010 SHALL have port CTRL, output, 11, datapath control field of the pipeline register.
REQ-011 SHALL have port STATE, output, 2, with encoding HALT=0, RUN=1, STEP=2, FAULT=3.
REQ-012 SHALL have port CYC, output, 16, executed-microword count (see Configuration).

Function
REQ-013 SHALL decode the microword CS_Q as: [31:28] I, [27:16] D, [15:13] CSEL, [12] CPOL, [11] HBIT, [10:0] CTRL.
REQ-014 SHALL load the pipeline register on every CP edge with either the fetched word or the HOLD word (I=4'hE CONT, CI=0, CSEL=0, other fields 0).
- All am2910 outputs come from this register, giving one cycle of fetch latency.
REQ-015 SHALL drive CI=1 for fetched words; RLD=1 and OE=0 at all times.
REQ-016 SHALL drive CCEN=1 when the registered CSEL=0, otherwise CCEN=0.
REQ-017 SHALL drive CC=~(COND[CSEL]^CPOL), combinational from live COND.
- CC low means pass.
- CC is 1 when CSEL=0.
REQ-018 In HALT, SHALL load HOLD each cycle so that Y is frozen.
- RUN_REQ moves to RUN and the current CS_Q is loaded on the same edge.
- Otherwise STEP_REQ moves to STEP and CS_Q is loaded.
REQ-019 STEP SHALL last exactly one cycle, loading HOLD on the way back to HALT.
REQ-020 In RUN, SHALL load CS_Q each cycle.
- HALT_REQ moves to HALT and loads HOLD.
- A fetched word with HBIT=1 is loaded, and HALT is entered on the following edge.
REQ-021 SHALL apply command priority HALT_REQ > RUN_REQ > STEP_REQ.
- Requests that do not apply in the current state are ignored.
REQ-022 SHALL enter FAULT when the registered I is in {1 CJS, 4 PUSH, 5 JSRP} while FULL=1 and the state is RUN or STEP.
- FAULT loads HOLD, is sticky, and ignores all requests.
- FAULT overrides HALT_REQ and HBIT arriving in the same cycle.

Reset
REQ-023 When RESET_N=0 at a CP edge, SHALL set STATE=HALT, CYC=0, and the pipeline register to I=0 (JZ), D=0, CSEL=0, CTRL=0, CI=1.
- Outputs are therefore I=0, CCEN=1, CC=1, CI=1 and the am2910 goes to address 0.
REQ-024 The first cycle after reset SHALL load HOLD.
REQ-025 Reset mid-RUN or in FAULT SHALL abandon the current state immediately, with no drain.

Configuration
REQ-026 With MICRO_CTRL_CYCCNT_EN defined, CYC SHALL increment once per fetched word (RUN and STEP loads) and saturate at 16'hFFFF.
REQ-027 Without MICRO_CTRL_CYCCNT_EN, CYC SHALL be constant 0 and no counter logic shall exist.

Structure
REQ-028 SHALL take from package micro_ctrl_pkg:
- am2910 opcode constants (JZ, CJS, PUSH, JSRP, CONT);
- microword field bit positions;
- the HOLD word constant;
- the state enumeration.
REQ-029 SHALL implement the CC/CCEN condition-select logic in sub-module micro_cc_mux; all other logic stays in micro_ctrl.

Verification
REQ-030 Reset, then one cycle of RUN_REQ with CS_Q=32'h4002_0000 -> after the load edge, I=4, D=12'h002, CCEN=1, CC=1, STATE=RUN.
REQ-031 RUN with CS_Q CSEL=3 and CPOL=0, toggling COND[3] 0->1 -> CC follows 1->0 in the same cycle, and CCEN=0.
REQ-032 HALT, pulse STEP_REQ with CS_Q=32'hE000_0005 -> STATE sequence 0,2,0; CTRL=11'h005 for exactly one cycle, then the HOLD word (I=E, CI=0); CYC=1 with the macro defined.
REQ-033 RUN, fetch a word with HBIT=1 -> that word is loaded, STATE=HALT on the next edge, and HOLD is loaded after that.
REQ-034 RUN with registered I=1 (CJS) and FULL=1 -> STATE=FAULT on the next edge; a later RUN_REQ is ignored; RESET_N=0 returns STATE to HALT with I=0.
REQ-035 RUN for 70000 cycles with the macro defined -> CYC saturates at 16'hFFFF; without the macro, CYC stays 0.
